fwrisc_exec_v2: RTL and testbench

Parametrised next-generation execute stage for the FWRISC core, between the decoder and the register file / CSR file. It sequences ALU, branch, jump, CSR, mul/div/shift, load/store and system instructions, and writes results and trap CSRs through the single `rd` write port. Over the first-generation execute stage it adds:
- a configurable number of data-execution-protection (DEP) regions,
- a configurable reset vector,
- a direct data-bus master with a load/store timeout,
- optional machine external interrupts.

---
 rtl/fwrisc_exec_v2.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_fwrisc_exec_v2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_exec_v2.sv
// fwrisc_exec_v2: FWRISC execute stage with DEP regions, data-bus master and optional IRQ entry (macro FWRISC_EXEC_V2_IRQ_EN).
// Latency: 1 cycle ALU/not-taken, 2 taken/jump/CSR/MDS, 2+waits load/store, 4+ trap entry.
// Backpressure: decode_valid held until instr_complete; dvalid held until dready or timeout.
module fwrisc_exec_v2 #(
    parameter bit          ENABLE_COMPRESSED = 1,
    parameter bit          ENABLE_MUL_DIV    = 1,
    parameter int unsigned DEP_REGIONS       = 2,
    parameter logic [31:0] RESET_VECTOR      = 32'h8000_0000,
    parameter int unsigned LDST_TIMEOUT      = 16,
    localparam int unsigned DEP_W            = (DEP_REGIONS > 0) ? DEP_REGIONS : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 decode_valid,
    output logic                 instr_complete,
    input  logic                 instr_c,
    input  logic [4:0]           op_type,
    input  logic [5:0]           op,
    input  logic [31:0]          op_a,
    input  logic [31:0]          op_b,
    input  logic [31:0]          op_c,
    input  logic [5:0]           rd,
    output logic [5:0]           rd_waddr,
    output logic [31:0]          rd_wdata,
    output logic                 rd_wen,
    output logic [31:0]          pc,
    output logic                 pc_seq,
    input  logic [31:0]          mtvec,
    input  logic [32*DEP_W-1:0]  dep_lo,
    input  logic [32*DEP_W-1:0]  dep_hi,
    input  logic                 irq,
    input  logic                 irq_en,
    output logic [31:0]          daddr,
    output logic                 dvalid,
    output logic                 dwrite,
    output logic [31:0]          dwdata,
    output logic [3:0]           dwstb,
    input  logic [31:0]          drdata,
    input  logic                 dready
);
    localparam logic [4:0] OPT_ARITH = 5'd0, OPT_BRANCH = 5'd1, OPT_LDST = 5'd2, OPT_MDS = 5'd3,
                           OPT_JUMP = 5'd4, OPT_SYSTEM = 5'd5, OPT_CSR = 5'd6;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                           ALU_CLR = 4'd5, ALU_EQ = 4'd6, ALU_NE = 4'd7, ALU_LT = 4'd8, ALU_GE = 4'd9,
                           ALU_LTU = 4'd10, ALU_GEU = 4'd11, ALU_OPA = 4'd12, ALU_OPB = 4'd13;
    localparam logic [2:0] LS_LB = 3'd0, LS_LH = 3'd1, LS_LW = 3'd2, LS_LBU = 3'd3, LS_LHU = 3'd4,
                           LS_SB = 3'd5, LS_SH = 3'd6, LS_SW = 3'd7;
    localparam logic [5:0] SYS_ECALL = 6'd0, SYS_EBREAK = 6'd1, SYS_ERET = 6'd2;
    localparam logic [5:0] CSR_MEPC = 6'h21, CSR_MCAUSE = 6'h22, CSR_MTVAL = 6'h23;
    localparam int unsigned TMO_M1 = (LDST_TIMEOUT > 0) ? LDST_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        ST_EXECUTE, ST_BRANCH_TAKEN, ST_JUMP, ST_CSR, ST_MDS_COMPLETE,
        ST_LDST_COMPLETE, ST_EXC_1, ST_EXC_2, ST_EXC_3
    } exec_state_e;

    exec_state_e state, state_n;
    logic [31:0] pc_n, mcause_q, mcause_n, mtval_q, mtval_n, ldst_addr, ldst_addr_n, cnt, cnt_n;
    logic        pc_seq_n, complete_n, wen, mds_start, mds_valid, irq_take, dep_ok;
    logic [31:0] alu_out, pc_inc, tgt_sum, target, addr_c, mds_out, ld_shift, ld_data;
    logic        is_store, misaligned;
    logic        unused_bits;

    assign unused_bits = ^{dep_lo, dep_hi, op[5:4]};

`ifdef FWRISC_EXEC_V2_IRQ_EN
    assign irq_take = irq && irq_en;
`else
    logic unused_irq;
    assign irq_take   = 1'b0;
    assign unused_irq = irq ^ irq_en;
`endif

    always_comb begin
        alu_out = 32'b0;
        case (op[3:0])
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_XOR: alu_out = op_a ^ op_b;
            ALU_CLR: alu_out = op_b & ~op_a;
            ALU_EQ:  alu_out = {31'b0, op_a == op_b};
            ALU_NE:  alu_out = {31'b0, op_a != op_b};
            ALU_LT:  alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_GE:  alu_out = {31'b0, $signed(op_a) >= $signed(op_b)};
            ALU_LTU: alu_out = {31'b0, op_a < op_b};
            ALU_GEU: alu_out = {31'b0, op_a >= op_b};
            ALU_OPA: alu_out = op_a;
            ALU_OPB: alu_out = op_b;
            default: alu_out = 32'b0;
        endcase
    end

    assign pc_inc  = pc + (instr_c ? 32'd2 : 32'd4);
    assign tgt_sum = (state == ST_JUMP) ? (op_a + op_b) : (pc + op_c);
    assign target  = {tgt_sum[31:1], 1'b0};
    assign addr_c  = op_a + op_c;

    // A region counts only when both bounds carry the enable bit.
    if (DEP_REGIONS > 0) begin : g_dep
        logic [DEP_W-1:0] reg_en, reg_hit;
        for (genvar i = 0; i < DEP_W; i++) begin : g_region
            assign reg_en[i]  = dep_lo[32*i] & dep_hi[32*i];
            assign reg_hit[i] = reg_en[i] && (target[31:3] >= dep_lo[32*i+3 +: 29])
                                          && (target[31:3] <= dep_hi[32*i+3 +: 29]);
        end
        assign dep_ok = (reg_en == '0) || (|reg_hit);
    end else begin : g_no_dep
        assign dep_ok = 1'b1;
    end

    assign is_store = (op[2:0] == LS_SB) || (op[2:0] == LS_SH) || (op[2:0] == LS_SW);
    always_comb begin
        misaligned = 1'b0;
        case (op[2:0])
            LS_LH, LS_LHU, LS_SH: misaligned = addr_c[0];
            LS_LW, LS_SW:         misaligned = |addr_c[1:0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign ld_shift = drdata >> {ldst_addr[1:0], 3'b000};
    always_comb begin
        ld_data = drdata;
        case (op[2:0])
            LS_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LS_LBU:  ld_data = {24'b0, ld_shift[7:0]};
            LS_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LS_LHU:  ld_data = {16'b0, ld_shift[15:0]};
            default: ld_data = drdata;
        endcase
    end

    fwrisc_mul_div_shift #(.ENABLE_MUL_DIV(ENABLE_MUL_DIV)) u_mds (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (mds_start),
        .op        (op[3:0]),
        .in_a      (op_a),
        .in_b      (op_b),
        .out_valid (mds_valid),
        .result    (mds_out)
    );

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pc_seq_n    = pc_seq;
        complete_n  = 1'b0;
        mcause_n    = mcause_q;
        mtval_n     = mtval_q;
        ldst_addr_n = ldst_addr;
        cnt_n       = cnt;
        wen         = 1'b0;
        rd_waddr    = rd;
        rd_wdata    = alu_out;
        mds_start   = 1'b0;
        dvalid      = 1'b0;
        dwrite      = 1'b0;
        dwdata      = 32'b0;
        dwstb       = 4'b0;
        daddr       = {ldst_addr[31:2], 2'b00};
        case (state)
            ST_EXECUTE: begin
                // The retire cycle still shows the old decode; it must not issue twice.
                if (decode_valid && !instr_complete) begin
                    if (irq_take) begin
                        mcause_n = 32'h8000_000B;
                        mtval_n  = 32'b0;
                        state_n  = ST_EXC_1;
                    end else begin
                        case (op_type)
                            OPT_ARITH: begin
                                wen = 1'b1; pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1;
                            end
                            OPT_BRANCH: begin
                                if (alu_out[0]) state_n = ST_BRANCH_TAKEN;
                                else begin pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1; end
                            end
                            OPT_JUMP: begin
                                wen = 1'b1; rd_wdata = pc_inc; state_n = ST_JUMP;
                            end
                            OPT_CSR: begin
                                wen = 1'b1; rd_waddr = op_c[5:0]; state_n = ST_CSR;
                            end
                            OPT_MDS: begin
                                mds_start = 1'b1; state_n = ST_MDS_COMPLETE;
                            end
                            OPT_LDST: begin
                                ldst_addr_n = addr_c;
                                cnt_n       = 32'b0;
                                if (misaligned) begin
                                    mcause_n = is_store ? 32'd6 : 32'd4;
                                    mtval_n  = addr_c;
                                    state_n  = ST_EXC_1;
                                end else begin
                                    state_n = ST_LDST_COMPLETE;
                                end
                            end
                            OPT_SYSTEM: begin
                                if (op == SYS_ERET) begin
                                    pc_n = op_a; pc_seq_n = 1'b0; complete_n = 1'b1;
                                end else begin
                                    mcause_n = (op == SYS_EBREAK) ? 32'd3 : 32'd11;
                                    mtval_n  = 32'b0;
                                    state_n  = ST_EXC_1;
                                end
                            end
                            default: begin
                                pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_BRANCH_TAKEN, ST_JUMP: begin
                if (!dep_ok) begin
                    mcause_n = 32'd1; mtval_n = target; state_n = ST_EXC_1;
                end else if (!ENABLE_COMPRESSED && target[1]) begin
                    mcause_n = 32'd0; mtval_n = target; state_n = ST_EXC_1;
                end else begin
                    pc_n = target; pc_seq_n = 1'b0; complete_n = 1'b1; state_n = ST_EXECUTE;
                end
            end
            ST_CSR: begin
                wen = 1'b1; rd_wdata = op_b;
                pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1; state_n = ST_EXECUTE;
            end
            ST_MDS_COMPLETE: begin
                if (mds_valid) begin
                    wen = 1'b1; rd_wdata = mds_out;
                    pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1; state_n = ST_EXECUTE;
                end
            end
            ST_LDST_COMPLETE: begin
                dvalid = 1'b1;
                dwrite = is_store;
                if (is_store) begin
                    case (op[2:0])
                        LS_SB:   begin dwdata = {4{op_b[7:0]}};  dwstb = 4'b0001 << ldst_addr[1:0]; end
                        LS_SH:   begin dwdata = {2{op_b[15:0]}}; dwstb = ldst_addr[1] ? 4'b1100 : 4'b0011; end
                        default: begin dwdata = op_b;            dwstb = 4'b1111; end
                    endcase
                end
                // dready is checked first so it wins over a coincident timeout.
                if (dready) begin
                    wen = !is_store; rd_wdata = ld_data;
                    pc_n = pc_inc; pc_seq_n = 1'b1; complete_n = 1'b1; state_n = ST_EXECUTE;
                end else if ((LDST_TIMEOUT != 0) && (cnt == TMO_M1)) begin
                    mcause_n = is_store ? 32'd7 : 32'd5;
                    mtval_n  = ldst_addr;
                    state_n  = ST_EXC_1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            ST_EXC_1: begin
                wen = 1'b1; rd_waddr = CSR_MEPC; rd_wdata = pc; state_n = ST_EXC_2;
            end
            ST_EXC_2: begin
                wen = 1'b1; rd_waddr = CSR_MTVAL; rd_wdata = mtval_q; state_n = ST_EXC_3;
            end
            ST_EXC_3: begin
                wen = 1'b1; rd_waddr = CSR_MCAUSE; rd_wdata = mcause_q;
                pc_n = mtvec; pc_seq_n = 1'b0; complete_n = 1'b1; state_n = ST_EXECUTE;
            end
            default: state_n = ST_EXECUTE;
        endcase
    end

    assign rd_wen = wen && !instr_complete && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_EXECUTE;
            pc             <= RESET_VECTOR;
            pc_seq         <= 1'b1;
            instr_complete <= 1'b0;
            mcause_q       <= 32'b0;
            mtval_q        <= 32'b0;
            ldst_addr      <= 32'b0;
            cnt            <= 32'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            pc_seq         <= pc_seq_n;
            instr_complete <= complete_n;
            mcause_q       <= mcause_n;
            mtval_q        <= mtval_n;
            ldst_addr      <= ldst_addr_n;
            cnt            <= cnt_n;
        end
    end
endmodule

// fwrisc_mul_div_shift: shift, multiply and unsigned divide/remainder unit.
// Latency: result registered one cycle after in_valid. Backpressure: none, accepts every in_valid.
// Ops: 0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 DIVU, 5 REMU; mul/div return 0 when ENABLE_MUL_DIV is 0.
module fwrisc_mul_div_shift #(
    parameter bit ENABLE_MUL_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    output logic [31:0] result
);
    logic [31:0] res_c;

    always_comb begin
        res_c = 32'b0;
        case (op)
            4'd0: res_c = in_a << in_b[4:0];
            4'd1: res_c = in_a >> in_b[4:0];
            4'd2: res_c = $signed(in_a) >>> in_b[4:0];
            4'd3: res_c = ENABLE_MUL_DIV ? in_a * in_b : 32'b0;
            // Divide by zero follows the RISC-V convention: all ones / dividend.
            4'd4: res_c = !ENABLE_MUL_DIV ? 32'b0 : (in_b == 32'b0) ? 32'hFFFF_FFFF : in_a / in_b;
            4'd5: res_c = !ENABLE_MUL_DIV ? 32'b0 : (in_b == 32'b0) ? in_a : in_a % in_b;
            default: res_c = 32'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= 32'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) result <= res_c;
        end
    end
endmodule

// File: tb/tb_fwrisc_exec_v2.sv
// Directed-vector bench for fwrisc_exec_v2 (DEP_REGIONS=2, LDST_TIMEOUT=16, mtvec=0x400).
module tb_fwrisc_exec_v2;
    localparam logic [4:0] T_ARITH = 5'd0, T_BRANCH = 5'd1, T_LDST = 5'd2, T_MDS = 5'd3,
                           T_JUMP = 5'd4, T_SYSTEM = 5'd5, T_CSR = 5'd6;
    localparam logic [5:0] A_ADD = 6'd0, A_OR = 6'd3, A_XOR = 6'd4, A_EQ = 6'd6, A_NE = 6'd7;
    localparam logic [5:0] M_SRA = 6'd2, M_MUL = 6'd3;
    localparam logic [5:0] L_LB = 6'd0, L_LW = 6'd2, L_LHU = 6'd4, L_SB = 6'd5, L_SW = 6'd7;
    localparam logic [5:0] S_ECALL = 6'd0, S_ERET = 6'd2;
    localparam int MEPC = 'h21, MCAUSE = 'h22, MTVAL = 'h23;

    logic        clock = 1'b0, reset = 1'b1;
    logic        decode_valid = 1'b0, instr_c = 1'b0;
    logic [4:0]  op_type = '0;
    logic [5:0]  op = '0, rd = '0;
    logic [31:0] op_a = '0, op_b = '0, op_c = '0;
    logic        instr_complete, rd_wen, pc_seq, dvalid, dwrite;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata, pc, daddr, dwdata;
    logic [3:0]  dwstb;
    logic [31:0] mtvec = 32'h400;
    logic [63:0] dep_lo = '0, dep_hi = '0;
    logic        irq = 1'b0, irq_en = 1'b0;
    logic [31:0] drdata = '0;
    logic        dready = 1'b0;

    int n_checks = 0, n_err = 0;
    logic [31:0] wr_data [64];
    bit          wr_seen [64];
    int          dv_cnt, lat;
    logic [31:0] last_daddr, last_dwdata, exp_pc;
    logic [3:0]  last_dwstb;
    logic        last_dwrite;

    fwrisc_exec_v2 #(.DEP_REGIONS(2), .LDST_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .decode_valid(decode_valid), .instr_complete(instr_complete),
        .instr_c(instr_c), .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .rd(rd), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen), .pc(pc), .pc_seq(pc_seq),
        .mtvec(mtvec), .dep_lo(dep_lo), .dep_hi(dep_hi), .irq(irq), .irq_en(irq_en),
        .daddr(daddr), .dvalid(dvalid), .dwrite(dwrite), .dwdata(dwdata), .dwstb(dwstb),
        .drdata(drdata), .dready(dready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one instruction, records rd writes and bus activity, returns cycles to instr_complete.
    task automatic run_instr(input logic [4:0] t, input logic [5:0] o, input logic [31:0] a, b, c,
                             input logic [5:0] r, input logic ic, input int waits,
                             input logic [31:0] rdata, output int latency);
        int cyc;
        for (int i = 0; i < 64; i++) begin wr_seen[i] = 1'b0; wr_data[i] = 32'hxxxx_xxxx; end
        dv_cnt = 0; last_daddr = 'x; last_dwdata = 'x; last_dwstb = 'x; last_dwrite = 1'bx;
        op_type = t; op = o; op_a = a; op_b = b; op_c = c; rd = r; instr_c = ic; decode_valid = 1'b1;
        latency = -1;
        cyc = 0;
        while (latency < 0) begin
            #1;
            if (dvalid) begin
                dv_cnt++;
                last_daddr = daddr; last_dwdata = dwdata; last_dwstb = dwstb; last_dwrite = dwrite;
                drdata = rdata;
                dready = (waits >= 0) && (dv_cnt > waits);
            end
            #1;
            if (rd_wen) begin wr_seen[rd_waddr] = 1'b1; wr_data[rd_waddr] = rd_wdata; end
            @(posedge clock); cyc++;
            #1;
            dready = 1'b0;
            if (instr_complete) latency = cyc;
            else if (cyc >= 200) begin
                chk("complete_seen", {31'b0, instr_complete}, 32'd1);
                latency = 0;
            end
        end
        decode_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset with a pending decode: no write may leak out.
        op_type = T_ARITH; op = A_ADD; op_a = 32'd3; op_b = 32'd4; rd = 6'd5; decode_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rd_wen", {31'b0, rd_wen}, 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_pc_seq", {31'b0, pc_seq}, 32'd1);
        chk("rst_complete", {31'b0, instr_complete}, 32'd0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'd0);
        chk("rst_dwstb", {28'b0, dwstb}, 32'd0);
        decode_valid = 1'b0; reset = 1'b0;
        @(posedge clock); #1;

        run_instr(T_ARITH, A_ADD, 32'd3, 32'd4, 32'd0, 6'd5, 1'b0, -1, 32'd0, lat);
        chk("add_wdata", wr_data[5], 32'd7);
        chk("add_lat", lat, 32'd1);
        chk("add_pc", pc, 32'h8000_0004);
        chk("add_pc_seq", {31'b0, pc_seq}, 32'd1);

        run_instr(T_ARITH, A_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 6'd6, 1'b1, -1, 32'd0, lat);
        chk("xor_wdata", wr_data[6], 32'h0000_FF00);
        chk("xor_c_pc", pc, 32'h8000_0006);

        run_instr(T_BRANCH, A_EQ, 32'd1, 32'd2, 32'h100, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("bnt_lat", lat, 32'd1);
        chk("bnt_pc", pc, 32'h8000_000A);

        run_instr(T_BRANCH, A_NE, 32'd1, 32'd2, 32'h100, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("bt_lat", lat, 32'd2);
        chk("bt_pc", pc, 32'h8000_010A);
        chk("bt_pc_seq", {31'b0, pc_seq}, 32'd0);

        run_instr(T_JUMP, A_ADD, 32'h2000, 32'h801, 32'd0, 6'd1, 1'b0, -1, 32'd0, lat);
        chk("jal_link", wr_data[1], 32'h8000_010E);
        chk("jal_lat", lat, 32'd2);
        chk("jal_pc", pc, 32'h2800);

        // Region 1 = [0x2000, 0x2FFF], region 0 left disabled.
        dep_lo = {32'h0000_2001, 32'h0}; dep_hi = {32'h0000_2FFF, 32'h0};
        run_instr(T_JUMP, A_ADD, 32'h3000, 32'd0, 32'd0, 6'd1, 1'b0, -1, 32'd0, lat);
        chk("dep_link", wr_data[1], 32'h2804);
        chk("dep_mepc", wr_data[MEPC], 32'h2800);
        chk("dep_mtval", wr_data[MTVAL], 32'h3000);
        chk("dep_mcause", wr_data[MCAUSE], 32'd1);
        chk("dep_pc", pc, 32'h400);
        chk("dep_pc_seq", {31'b0, pc_seq}, 32'd0);

        run_instr(T_JUMP, A_ADD, 32'h2800, 32'd0, 32'd0, 6'd1, 1'b0, -1, 32'd0, lat);
        chk("dep_ok_pc", pc, 32'h2800);
        chk("dep_ok_nomcause", {31'b0, wr_seen[MCAUSE]}, 32'd0);

        run_instr(T_BRANCH, A_EQ, 32'd5, 32'd5, 32'hFFFF_F800, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("dep_lo_edge_pc", pc, 32'h2000);
        dep_lo = '0; dep_hi = '0;

        run_instr(T_CSR, A_OR, 32'h0F, 32'hF0, 32'h30, 6'd7, 1'b0, -1, 32'd0, lat);
        chk("csr_new", wr_data['h30], 32'hFF);
        chk("csr_old", wr_data[7], 32'hF0);
        chk("csr_lat", lat, 32'd2);
        chk("csr_pc", pc, 32'h2004);

        run_instr(T_MDS, M_MUL, 32'd6, 32'd7, 32'd0, 6'd8, 1'b0, -1, 32'd0, lat);
        chk("mul_wdata", wr_data[8], 32'd42);
        chk("mul_lat", lat, 32'd2);
        run_instr(T_MDS, M_SRA, 32'h8000_0000, 32'd4, 32'd0, 6'd8, 1'b0, -1, 32'd0, lat);
        chk("sra_wdata", wr_data[8], 32'hF800_0000);

        run_instr(T_LDST, L_LB, 32'h100, 32'd0, 32'd3, 6'd9, 1'b0, 3, 32'h8012_3456, lat);
        chk("lb_daddr", last_daddr, 32'h100);
        chk("lb_dwstb", {28'b0, last_dwstb}, 32'd0);
        chk("lb_dwrite", {31'b0, last_dwrite}, 32'd0);
        chk("lb_wdata", wr_data[9], 32'hFFFF_FF80);
        chk("lb_lat", lat, 32'd5);

        run_instr(T_LDST, L_LHU, 32'h100, 32'd0, 32'd2, 6'd10, 1'b0, 0, 32'h8001_1234, lat);
        chk("lhu_wdata", wr_data[10], 32'h0000_8001);
        chk("lhu_lat", lat, 32'd2);

        run_instr(T_LDST, L_SB, 32'h100, 32'h0000_12AB, 32'd1, 6'd0, 1'b0, 0, 32'd0, lat);
        chk("sb_dwstb", {28'b0, last_dwstb}, 32'b0010);
        chk("sb_dwdata", last_dwdata, 32'hABAB_ABAB);
        chk("sb_dwrite", {31'b0, last_dwrite}, 32'd1);
        chk("sb_pc", pc, 32'h2018);

        // dready on the last allowed cycle beats the timeout.
        run_instr(T_LDST, L_LW, 32'h300, 32'd0, 32'd0, 6'd11, 1'b0, 15, 32'h1122_3344, lat);
        chk("edge_dvcnt", dv_cnt, 32'd16);
        chk("edge_wdata", wr_data[11], 32'h1122_3344);
        chk("edge_nocause", {31'b0, wr_seen[MCAUSE]}, 32'd0);
        chk("edge_pc", pc, 32'h201C);

        run_instr(T_LDST, L_SW, 32'h200, 32'hDEAD_BEEF, 32'd0, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("tmo_dvcnt", dv_cnt, 32'd16);
        chk("tmo_dvalid_low", {31'b0, dvalid}, 32'd0);
        chk("tmo_mcause", wr_data[MCAUSE], 32'd7);
        chk("tmo_mtval", wr_data[MTVAL], 32'h200);
        chk("tmo_mepc", wr_data[MEPC], 32'h201C);
        chk("tmo_pc", pc, 32'h400);

        run_instr(T_LDST, L_LW, 32'h100, 32'd0, 32'd2, 6'd12, 1'b0, 0, 32'd0, lat);
        chk("mis_dvcnt", dv_cnt, 32'd0);
        chk("mis_mcause", wr_data[MCAUSE], 32'd4);
        chk("mis_mtval", wr_data[MTVAL], 32'h102);
        chk("mis_lat", lat, 32'd4);

        run_instr(T_SYSTEM, S_ECALL, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("ecall_mcause", wr_data[MCAUSE], 32'd11);
        chk("ecall_mepc", wr_data[MEPC], 32'h400);
        chk("ecall_lat", lat, 32'd4);

        run_instr(T_SYSTEM, S_ERET, 32'h1234, 32'd0, 32'd0, 6'd0, 1'b0, -1, 32'd0, lat);
        chk("eret_pc", pc, 32'h1234);
        chk("eret_pc_seq", {31'b0, pc_seq}, 32'd0);

        irq = 1'b1; irq_en = 1'b1;
        run_instr(T_ARITH, A_ADD, 32'd3, 32'd4, 32'd0, 6'd5, 1'b0, -1, 32'd0, lat);
`ifdef FWRISC_EXEC_V2_IRQ_EN
        chk("irq_no_rd", {31'b0, wr_seen[5]}, 32'd0);
        chk("irq_mepc", wr_data[MEPC], 32'h1234);
        chk("irq_mcause", wr_data[MCAUSE], 32'h8000_000B);
        chk("irq_mtval", wr_data[MTVAL], 32'd0);
        chk("irq_pc", pc, 32'h400);
        exp_pc = 32'h404;
`else
        chk("irq_off_rd", wr_data[5], 32'd7);
        chk("irq_off_pc", pc, 32'h1238);
        exp_pc = 32'h123C;
`endif
        irq_en = 1'b0;
        run_instr(T_ARITH, A_ADD, 32'd1, 32'd1, 32'd0, 6'd6, 1'b0, -1, 32'd0, lat);
        chk("irq_dis_rd", wr_data[6], 32'd2);
        chk("irq_dis_pc", pc, exp_pc);
        irq = 1'b0;

        // Reset while the bus request is outstanding.
        op_type = T_LDST; op = L_LW; op_a = 32'h100; op_c = 32'd0; rd = 6'd3; decode_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("mid_dvalid_hi", {31'b0, dvalid}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_dvalid", {31'b0, dvalid}, 32'd0);
        chk("mid_rst_pc", pc, 32'h8000_0000);
        chk("mid_rst_pc_seq", {31'b0, pc_seq}, 32'd1);
        decode_valid = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_dvalid", {31'b0, dvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
